// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: T-state encoding,
// opcode values, IR field positions and the decode classes used at T3.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHRA = 5'b01000;
    localparam logic [4:0] OPC_SHL  = 5'b01001;
    localparam logic [4:0] OPC_ROR  = 5'b01010;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [2:0] {
        CLS_BIN, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILL
    } cls_t;

    function automatic cls_t decode_class(input logic [4:0] opc);
        cls_t cls;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
            OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: cls = CLS_BIN;
            OPC_MUL, OPC_DIV:                    cls = CLS_MULDIV;
            OPC_NEG, OPC_NOT:                    cls = CLS_UNARY;
            OPC_NOP:                             cls = CLS_NOP;
            OPC_HALT:                            cls = CLS_HALT;
            default:                             cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select converter; indices at or above REG_COUNT
// select nothing.
module reg_select_decoder #(
    parameter int REG_COUNT = 16
) (
    input  logic [3:0]           index,
    input  logic                 enable,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (enable && (int'(index) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch plus ALU/unary/mul-div/nop/halt T-states.
// Optional `define MEM_WAIT_EN stretches T1 until mem_ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int OPC_W     = 5
) (
    input  logic                 Clock,
    input  logic                 clear,
    input  logic [31:0]          IR,
    input  logic                 mem_ready,
    output logic [REG_COUNT-1:0] Rin,
    output logic [REG_COUNT-1:0] Rout,
    output logic                 PCout,
    output logic                 PCin,
    output logic                 IncPC,
    output logic                 MARin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 HIin,
    output logic                 LOin,
    output logic [OPC_W-1:0]     opcode,
    output logic                 Run,
    output logic                 illegal_op
);

    state_t      state;
    state_t      state_next;
    cls_t        cls;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [4:0]  opc;
    logic        rin_en;
    logic        rout_en;
    logic [3:0]  rin_idx;
    logic [3:0]  rout_idx;
    logic        t1_first;

    assign opc = IR[OPC_MSB:OPC_LSB];
    assign ra  = IR[RA_MSB:RA_LSB];
    assign rb  = IR[RB_MSB:RB_LSB];
    assign rc  = IR[RC_MSB:RC_LSB];
    assign cls = decode_class(opc);

    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

`ifdef MEM_WAIT_EN
    logic t1_wait;
    logic unused_ir;

    // Set while T1 is being held so PC is only reloaded on the first T1 cycle.
    always_ff @(posedge Clock) begin
        if (clear) begin
            t1_wait <= 1'b0;
        end else begin
            t1_wait <= (state == T1) && (state_next == T1);
        end
    end

    assign t1_first  = !t1_wait;
    assign unused_ir = ^IR[14:0];
`else
    logic unused_ir;

    assign t1_first  = 1'b1;
    assign unused_ir = ^{IR[14:0], mem_ready};
`endif

    always_comb begin
        state_next = state;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        opcode     = '0;
        illegal_op = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rin_idx    = ra;
        rout_idx   = rb;
        Run        = (state != HALT);

        case (state)
            T0: begin
                state_next = T1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
`ifdef MEM_WAIT_EN
                state_next = mem_ready ? T2 : T1;
`else
                state_next = T2;
`endif
                Read    = 1'b1;
                MDRin   = 1'b1;
                Zlowout = t1_first;
                PCin    = t1_first;
            end
            T2: begin
                state_next = T3;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_BIN: begin
                        state_next = T4;
                        rout_en    = 1'b1;
                        Yin        = 1'b1;
                    end
                    CLS_MULDIV: begin
                        state_next = T4;
                        rout_en    = 1'b1;
                        rout_idx   = ra;
                        Yin        = 1'b1;
                    end
                    CLS_UNARY: begin
                        state_next = T4;
                        rout_en    = 1'b1;
                        opcode     = opc;
                        Zin        = 1'b1;
                    end
                    CLS_HALT: state_next = HALT;
                    CLS_ILL: begin
                        state_next = T0;
                        illegal_op = 1'b1;
                    end
                    default: state_next = T0;
                endcase
            end
            T4: begin
                state_next = T0;
                case (cls)
                    CLS_BIN: begin
                        state_next = T5;
                        rout_en    = 1'b1;
                        rout_idx   = rc;
                        opcode     = opc;
                        Zin        = 1'b1;
                    end
                    CLS_MULDIV: begin
                        state_next = T5;
                        rout_en    = 1'b1;
                        opcode     = opc;
                        Zin        = 1'b1;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                state_next = T0;
                Zlowout    = 1'b1;
                if (cls == CLS_MULDIV) begin
                    state_next = T6;
                    LOin       = 1'b1;
                end else begin
                    rin_en = 1'b1;
                end
            end
            T6: begin
                state_next = T0;
                Zhighout   = 1'b1;
                HIin       = 1'b1;
            end
            HALT: state_next = HALT;
            default: state_next = T0;
        endcase

        // Clear forces a quiet bus for its cycle regardless of the state left behind.
        if (clear) begin
            PCout      = 1'b0;
            PCin       = 1'b0;
            IncPC      = 1'b0;
            MARin      = 1'b0;
            Read       = 1'b0;
            MDRin      = 1'b0;
            MDRout     = 1'b0;
            IRin       = 1'b0;
            Yin        = 1'b0;
            Zin        = 1'b0;
            Zlowout    = 1'b0;
            Zhighout   = 1'b0;
            HIin       = 1'b0;
            LOin       = 1'b0;
            opcode     = '0;
            illegal_op = 1'b0;
            rin_en     = 1'b0;
            rout_en    = 1'b0;
            Run        = 1'b1;
        end
    end

    reg_select_decoder #(.REG_COUNT(REG_COUNT)) u_rin_dec (
        .index  (rin_idx),
        .enable (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.REG_COUNT(REG_COUNT)) u_rout_dec (
        .index  (rout_idx),
        .enable (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction is expanded into its
// expected per-cycle strobe list and compared cycle by cycle.
module tb_control_sequencer;

    localparam logic [13:0] S_PCOUT = 14'h2000;
    localparam logic [13:0] S_PCIN  = 14'h1000;
    localparam logic [13:0] S_INCPC = 14'h0800;
    localparam logic [13:0] S_MARIN = 14'h0400;
    localparam logic [13:0] S_READ  = 14'h0200;
    localparam logic [13:0] S_MDRIN = 14'h0100;
    localparam logic [13:0] S_MDROUT= 14'h0080;
    localparam logic [13:0] S_IRIN  = 14'h0040;
    localparam logic [13:0] S_YIN   = 14'h0020;
    localparam logic [13:0] S_ZIN   = 14'h0010;
    localparam logic [13:0] S_ZLO   = 14'h0008;
    localparam logic [13:0] S_ZHI   = 14'h0004;
    localparam logic [13:0] S_HIIN  = 14'h0002;
    localparam logic [13:0] S_LOIN  = 14'h0001;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [4:0]  opcode;
    logic        Run, illegal_op;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] expq[$];

    always #5 Clock = ~Clock;

    control_sequencer #(.REG_COUNT(16), .OPC_W(5)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .opcode(opcode), .Run(Run), .illegal_op(illegal_op)
    );

    function automatic logic [63:0] pk(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [13:0] s, input logic [4:0] opc,
                                       input logic run, input logic ill);
        return {11'b0, rin, rout, s, opc, run, ill};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] v;
        v = 16'b0;
        v[i] = 1'b1;
        return v;
    endfunction

    logic [63:0] obs;
    assign obs = pk(Rin, Rout,
                    {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                     Yin, Zin, Zlowout, Zhighout, HIin, LOin},
                    opcode, Run, illegal_op);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected micro-operation list for one instruction, fetch included.
    task automatic build(input logic [31:0] ir, input int w, output bit is_halt);
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        opc = ir[31:27];
        ra  = ir[26:23];
        rb  = ir[22:19];
        rc  = ir[18:15];
        is_halt = 1'b0;
        expq.delete();
        expq.push_back(pk(0, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 1, 0));
        expq.push_back(pk(0, 0, S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 1, 0));
        for (int j = 0; j < w; j++) expq.push_back(pk(0, 0, S_READ | S_MDRIN, 0, 1, 0));
        expq.push_back(pk(0, 0, S_MDROUT | S_IRIN, 0, 1, 0));
        if (opc inside {[5'd3:5'd11]}) begin
            expq.push_back(pk(0, oh(rb), S_YIN, 0, 1, 0));
            expq.push_back(pk(0, oh(rc), S_ZIN, opc, 1, 0));
            expq.push_back(pk(oh(ra), 0, S_ZLO, 0, 1, 0));
        end else if (opc == 5'd15 || opc == 5'd16) begin
            expq.push_back(pk(0, oh(ra), S_YIN, 0, 1, 0));
            expq.push_back(pk(0, oh(rb), S_ZIN, opc, 1, 0));
            expq.push_back(pk(0, 0, S_ZLO | S_LOIN, 0, 1, 0));
            expq.push_back(pk(0, 0, S_ZHI | S_HIIN, 0, 1, 0));
        end else if (opc == 5'd17 || opc == 5'd18) begin
            expq.push_back(pk(0, oh(rb), S_ZIN, opc, 1, 0));
            expq.push_back(pk(oh(ra), 0, S_ZLO, 0, 1, 0));
        end else if (opc == 5'd26) begin
            expq.push_back(pk(0, 0, 0, 0, 1, 0));
        end else if (opc == 5'd27) begin
            expq.push_back(pk(0, 0, 0, 0, 1, 0));
            is_halt = 1'b1;
        end else begin
            expq.push_back(pk(0, 0, 0, 0, 1, 1));
        end
    endtask

    task automatic cycle(input logic [31:0] ir, input logic clr, input logic mr,
                         input logic [63:0] want, input string tag);
        @(posedge Clock);
        #1;
        IR        = ir;
        clear     = clr;
        mem_ready = mr;
        @(negedge Clock);
        chk(tag, obs, want);
    endtask

    task automatic run_instr(input logic [31:0] ir, input int w_req, input int abort_at,
                             input int hold, input string name);
        bit   is_halt;
        int   w;
        logic mr;
`ifdef MEM_WAIT_EN
        w = w_req;
`else
        w = 0;
`endif
        build(ir, w, is_halt);
        for (int k = 0; k < expq.size(); k++) begin
            mr = 1'($urandom);
`ifdef MEM_WAIT_EN
            if (k >= 1 && k <= 1 + w) mr = (k == 1 + w);
`endif
            if (k == abort_at) begin
                cycle(ir, 1'b1, mr, pk(0, 0, 0, 0, 1, 0), $sformatf("%s_abort_k%0d", name, k));
                return;
            end
            cycle(ir, 1'b0, mr, expq[k], $sformatf("%s_k%0d", name, k));
        end
        if (is_halt) begin
            for (int h = 0; h < hold; h++)
                cycle(ir, 1'b0, 1'($urandom), pk(0, 0, 0, 0, 0, 0), $sformatf("%s_halt%0d", name, h));
            cycle(ir, 1'b1, 1'($urandom), pk(0, 0, 0, 0, 1, 0), $sformatf("%s_halt_clr", name));
        end
    endtask

    initial begin
        logic [4:0]  legal [15];
        logic [4:0]  opc;
        logic [31:0] ir;
        int          w, ab;
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};

        clear     = 1'b1;
        IR        = 32'h0;
        mem_ready = 1'b0;
        @(negedge Clock);
        chk("reset", obs, pk(0, 0, 0, 0, 1, 0));

        run_instr(32'h18918000, 0, -1, 0, "add_r1r2r3");
        run_instr({5'b01111, 4'd4, 4'd5, 19'b0}, 0, -1, 0, "mul_r4r5");
        run_instr({5'b10010, 4'd6, 4'd7, 19'b0}, 0, -1, 0, "not_r6r7");
        run_instr({5'b11011, 27'b0}, 0, -1, 10, "halt");
        run_instr({5'b11111, 4'd3, 4'd2, 4'd1, 15'b0}, 0, -1, 0, "illegal");
        run_instr({5'b11010, 27'h5a5a5a5}, 0, -1, 0, "nop");
        run_instr(32'h18918000, 3, -1, 0, "add_wait3");
`ifdef MEM_WAIT_EN
        run_instr(32'h18918000, 2, 6, 0, "add_clr_t4");
`else
        run_instr(32'h18918000, 0, 4, 0, "add_clr_t4");
`endif
        run_instr({5'b10000, 4'd15, 4'd0, 4'd9, 15'b0}, 0, -1, 0, "div_r15r0");

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0) opc = 5'($urandom);
            else opc = legal[$urandom_range(0, 14)];
            ir = {opc, 27'($urandom)};
            w  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(ir, w, ab, $urandom_range(1, 5), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
